// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package add_sub_pkg;

    // k encoding: add when 0, subtract when 1
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Iteration counter width: clog2(n), never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple adder over one DIGIT-wide slice. c_msb exposes the
// carry into the top bit so the caller can form two's-complement overflow.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/adder_subtractor_serial.sv
// Digit-serial adder/subtractor with valid/ready on both sides. Operands are
// consumed DIGIT bits per cycle, LSB first; the result digit enters the sum
// register from the top so the word is aligned after N = WIDTH/DIGIT cycles.
module adder_subtractor_serial
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [DIGIT-1:0] d_s;
    logic             d_co;
    logic             d_cmsb;
    logic [WIDTH-1:0] sum_shift;
    logic             sub;

    assign sub = (k == MODE_SUB);

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (d_s),
        .co    (d_co),
        .c_msb (d_cmsb)
    );

    // New digit enters at the MSB end; with DIGIT == WIDTH it is the whole word
    if (DIGIT == WIDTH) begin : g_full
        assign sum_shift = d_s;
    end else begin : g_part
        assign sum_shift = {d_s, sum_q[WIDTH-1:DIGIT]};
    end

    // Control FSM plus operand/result datapath; every output is a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready comes up one edge after reset release
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // subtract = add the one's complement with carry-in 1
                        a_q      <= a;
                        b_q      <= b ^ {WIDTH{sub}};
                        carry_q  <= sub;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= d_co;
                    cnt_q   <= cnt_q + 1'b1;
                    sum_q   <= sum_shift;
                    if (cnt_q == LAST) begin
                        // final digit holds the word MSB: flags come from it
                        cout_q    <= d_co;
                        ovf_q     <= d_co ^ d_cmsb;
                        zero_q    <= (sum_shift == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_adder_subtractor_serial.sv
// Scoreboard bench: three configurations (8/2, 16/4, 8/8). The driver pushes
// the hand-computed result on accept; per-instance monitors check on out_valid.
module tb_adder_subtractor_serial;
    import add_sub_pkg::*;

    typedef struct {
        int          inst;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv, ir, ov, ordy, kk, co, of, zr;
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic [15:0] sv [3];
    logic [7:0]  s0, s2;
    logic [15:0] s1;
    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    // cycle counter used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    adder_subtractor_serial #(.WIDTH(8), .DIGIT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .k(kk[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(of[0]), .zero(zr[0]));

    adder_subtractor_serial #(.WIDTH(16), .DIGIT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .k(kk[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(of[1]), .zero(zr[1]));

    adder_subtractor_serial #(.WIDTH(8), .DIGIT(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2][7:0]), .b(bv[2][7:0]), .k(kk[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(of[2]), .zero(zr[2]));

    assign sv[0] = {8'h00, s0};
    assign sv[1] = s1;
    assign sv[2] = {8'h00, s2};

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic k, input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez, input int lat);
        exp_t e;
        int   n = 0;
        @(posedge clk); #1;
        av[i] = a; bv[i] = b; kk[i] = k; iv[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ir[i] && n < 100);
        if (!ir[i]) begin
            total++; bad++;
            $display("FAIL accept_timeout inst=%0d", i);
            iv[i] = 1'b0;
            return;
        end
        e.inst = i; e.sum = es; e.cout = ec; e.ovf = eo; e.zero = ez;
        e.acc = cyc; e.lat = lat;
        sbq.push_back(e);
        @(posedge clk); #1;
        iv[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout pending=%0d", sbq.size());
            sbq.delete();
        end
    endtask

    // one monitor per instance; results must match the head of the scoreboard
    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        bit seen = 1'b0;
        always @(negedge clk) begin
            if (!rst_n) begin
                seen = 1'b0;
            end else if (ov[gi]) begin
                if (sbq.size() == 0 || sbq[0].inst != gi) begin
                    total++; bad++;
                    $display("FAIL unexpected_result inst=%0d got sum=%0h", gi, sv[gi]);
                end else begin
                    if (!seen) begin
                        check($sformatf("latency%0d", gi), cyc - sbq[0].acc - 1, sbq[0].lat);
                        seen = 1'b1;
                    end
                    check($sformatf("sum%0d", gi), int'(sv[gi]), int'(sbq[0].sum));
                    check($sformatf("cout%0d", gi), int'(co[gi]), int'(sbq[0].cout));
                    check($sformatf("ovf%0d", gi), int'(of[gi]), int'(sbq[0].ovf));
                    check($sformatf("zero%0d", gi), int'(zr[gi]), int'(sbq[0].zero));
                    check($sformatf("busy_in_ready%0d", gi), int'(ir[gi]), 0);
                    if (ordy[gi]) begin
                        void'(sbq.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        iv = '0; kk = '0; ordy = 3'b111;
        for (int i = 0; i < 3; i++) begin
            av[i] = '0; bv[i] = '0;
        end

        // reset state
        #12;
        check("rst_in_ready", int'(ir[0]), 0);
        check("rst_out_valid", int'(ov[0]), 0);
        check("rst_sum", int'(s0), 0);
        check("rst_flags", int'({co[0], of[0], zr[0]}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", int'(ir[0]), 0);
        @(negedge clk);
        check("ready_after_edge", int'(ir[0]), 1);

        // basic vectors, WIDTH=8 DIGIT=2 (N=4)
        send(0, 16'h80, 16'hC8, MODE_ADD, 16'h48, 1'b1, 1'b1, 1'b0, 4);
        drain();
        send(0, 16'h80, 16'hC8, MODE_SUB, 16'hB8, 1'b0, 1'b0, 1'b0, 4);
        send(0, 16'h9D, 16'h20, MODE_ADD, 16'hBD, 1'b0, 1'b0, 1'b0, 4);
        drain();
        send(0, 16'h7C, 16'h18, MODE_SUB, 16'h64, 1'b1, 1'b0, 1'b0, 4);
        send(0, 16'h55, 16'h55, MODE_SUB, 16'h00, 1'b1, 1'b0, 1'b1, 4);
        send(0, 16'h7F, 16'h01, MODE_ADD, 16'h80, 1'b0, 1'b1, 1'b0, 4);
        drain();

        // backpressure, with in_valid toggling and new operands while busy
        ordy[0] = 1'b0;
        send(0, 16'h12, 16'h34, MODE_ADD, 16'h46, 1'b0, 1'b0, 1'b0, 4);
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            iv[0] = ~iv[0]; av[0] = 16'hFF; bv[0] = 16'hFF; kk[0] = MODE_SUB;
        end
        check("held_valid", int'(ov[0]), 1);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        drain();

        // reset during RUN
        send(0, 16'h0F, 16'h0F, MODE_ADD, 16'h1E, 1'b0, 1'b0, 1'b0, 4);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sbq.delete();
        #1;
        check("abort_in_ready", int'(ir[0]), 0);
        check("abort_out_valid", int'(ov[0]), 0);
        check("abort_sum", int'(s0), 0);
        check("abort_flags", int'({co[0], of[0], zr[0]}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_back", int'(ir[0]), 1);
        send(0, 16'h01, 16'h01, MODE_ADD, 16'h02, 1'b0, 1'b0, 1'b0, 4);
        drain();

        // parameter sweep
        send(1, 16'hFFFF, 16'h0001, MODE_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 4);
        drain();
        send(2, 16'h80, 16'hC8, MODE_ADD, 16'h48, 1'b1, 1'b1, 1'b0, 1);
        send(2, 16'h80, 16'hC8, MODE_SUB, 16'hB8, 1'b0, 1'b0, 1'b0, 1);
        drain();

        // nothing must appear after the last result
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov != 3'b000) n++;
        end
        check("quiet_after_drain", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
